// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm countdown timer: state encodings,
// the seconds-value width and the default clock rate.
package alarm_pkg;

  // Width of the seconds value latched from time_parameters.
  localparam int TIME_W = 4;

  // Default system clock rate. Test benches override this with a small value.
  localparam int DEFAULT_CLK_FREQ_HZ = 50_000_000;

  // Countdown FSM states. The unused code 2'b11 is treated as IDLE.
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    COUNTING = 2'b01,
    EXPIRED  = 2'b10
  } timer_state_e;

endpackage

// File: rtl/alarm_timer_tick_gen.sv
// Free-running prescaler that produces a one-cycle 1 Hz strobe and a
// 0.5 Hz strobe on every second 1 Hz strobe. sync_clear restarts both
// the prescaler and the half-rate phase, so that a countdown started
// on a sync_clear lasts an exact number of whole seconds.
module tick_gen
  import alarm_pkg::*;
#(
  parameter int CLK_FREQ_HZ = DEFAULT_CLK_FREQ_HZ,
  parameter int PRESC_W     = $clog2(CLK_FREQ_HZ)
) (
  input  logic clock,
  input  logic reset,
  input  logic sync_clear,
  output logic one_hz_enable,
  output logic half_hz_enable
);

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_FREQ_HZ - 1);

  logic [PRESC_W-1:0] prescaler;
  logic               phase;
  logic               tick;

  assign tick           = (prescaler == PRESC_MAX);
  assign one_hz_enable  = tick;
  assign half_hz_enable = tick & phase;

  // Prescaler wraps every CLK_FREQ_HZ cycles; the phase bit flips on each wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      phase     <= 1'b0;
    end else if (sync_clear) begin
      prescaler <= '0;
      phase     <= 1'b0;
    end else if (tick) begin
      prescaler <= '0;
      phase     <= ~phase;
    end else begin
      prescaler <= prescaler + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/alarm_timer.sv
// Countdown timer for the anti-theft alarm FSM. A rising edge on
// start_timer latches the seconds value and counts it down in whole
// seconds; expired stays high once the delay has elapsed until the next
// start. Also exports the free-running 1 Hz / 0.5 Hz LED blink strobes.
// Optional build macro ALARM_TIMER_REMAINING_EN adds the remaining_s
// debug/display output showing the seconds still to go.
module alarm_timer
  import alarm_pkg::*;
#(
  parameter int CLK_FREQ_HZ = DEFAULT_CLK_FREQ_HZ,
  parameter int PRESC_W     = $clog2(CLK_FREQ_HZ)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [TIME_W-1:0] value,
  input  logic              start_timer,
  output logic              expired,
  output logic              one_hz_enable,
  output logic              half_hz_enable
`ifdef ALARM_TIMER_REMAINING_EN
  ,
  output logic [TIME_W-1:0] remaining_s
`endif
);

  timer_state_e      state;
  timer_state_e      state_next;
  logic [TIME_W-1:0] remaining;
  logic [TIME_W-1:0] remaining_next;
  logic              start_q;
  logic              start_edge;

  // Only the rising edge of the request acts, so a held level starts once.
  assign start_edge = start_timer & ~start_q;

  tick_gen #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .PRESC_W     (PRESC_W)
  ) u_tick_gen (
    .clock          (clock),
    .reset          (reset),
    .sync_clear     (start_edge),
    .one_hz_enable  (one_hz_enable),
    .half_hz_enable (half_hz_enable)
  );

  assign expired = (state == EXPIRED);

  // State, remaining seconds and the start-request history register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      start_q   <= 1'b0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
      start_q   <= start_timer;
    end
  end

  // A start edge always reloads and wins over a coinciding final tick.
  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    if (start_edge) begin
      remaining_next = value;
      state_next     = (value == '0) ? EXPIRED : COUNTING;
    end else begin
      case (state)
        COUNTING: begin
          if (one_hz_enable) begin
            if (remaining == TIME_W'(1)) begin
              state_next     = EXPIRED;
              remaining_next = '0;
            end else begin
              remaining_next = remaining - TIME_W'(1);
            end
          end
        end
        EXPIRED: begin
          state_next = EXPIRED;
        end
        default: begin
          state_next     = IDLE;
          remaining_next = '0;
        end
      endcase
    end
  end

`ifdef ALARM_TIMER_REMAINING_EN
  assign remaining_s = (state == COUNTING) ? remaining : '0;
`else
  // Without the debug output the remaining count stays internal.
`endif

endmodule

// File: doc/alarm_timer.md
Name: alarm_timer

Overview:
- Countdown timer that serves the anti-theft alarm FSM in toplevel: the FSM requests a delay, and this block answers when that delay has elapsed.
- Latches a 4-bit seconds value from time_parameters when start_timer is requested, counts down in whole seconds and raises expired.
- Also generates the free-running 1 Hz and 0.5 Hz enable strobes used for status-LED blinking.
- Single clock domain; sits between time_parameters and the main alarm FSM.

Parameters:
- CLK_FREQ_HZ, 50_000_000, clock cycles per second; minimum 2; benches use 4.
- PRESC_W, $clog2(CLK_FREQ_HZ), prescaler counter width.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high; clears all state.
- value  input  4  countdown length in seconds; sampled only on a start request.
- start_timer  input  1  start request from the FSM; level or pulse accepted, and only its rising edge acts.
- expired  output  1  level; high while state is EXPIRED.
- one_hz_enable  output  1  one-cycle pulse every CLK_FREQ_HZ cycles.
- half_hz_enable  output  1  one-cycle pulse on every second one_hz_enable.

Behaviour:
- Reset values: state IDLE, prescaler 0, remaining 0, start_q 0, half-Hz phase bit 0. All outputs 0.
- Start request: start_edge = start_timer & ~start_q, where start_q is a registered copy of start_timer. Holding start_timer high therefore starts the timer once only.
- Prescaler: counts 0..CLK_FREQ_HZ-1 and wraps to 0.
  - tick = (prescaler == CLK_FREQ_HZ-1). one_hz_enable = tick, registered-free (combinational from the prescaler register).
  - The phase bit toggles on each tick. half_hz_enable = tick & phase.
  - A start_edge forces prescaler to 0 and phase to 0 on the next edge. This makes the countdown length exact.
- States: IDLE, COUNTING, EXPIRED.
  - IDLE: on start_edge, remaining <= value. Go to COUNTING, or straight to EXPIRED if value == 0.
  - COUNTING: on tick, remaining decrements. On a tick with remaining == 1, go to EXPIRED with remaining set to 0.
  - EXPIRED: expired = 1. Holds until start_edge, which reloads exactly as in IDLE.
  - Any state: a start_edge while COUNTING restarts the count with the new value.
- Latency: start_edge seen in cycle k.
  - expired first high in cycle k + value*CLK_FREQ_HZ + 1.
  - expired first high in cycle k+1 when value == 0.
- Simultaneous start_edge and final tick: the start wins. The count reloads and expired does not assert.
- value changing during COUNTING is ignored; the value is latched only at the start.
- Reset asserted mid-count: immediate return to IDLE, expired 0, no residual tick.
- The strobes run in every state, including IDLE.

Optional Feature:
- Macro ALARM_TIMER_REMAINING_EN.
- When defined: adds output remaining_s [3:0], which presents the current remaining register. It reads 0 in IDLE and EXPIRED. Intended for debug and the 7-segment display.
- When undefined: the port is absent and the functional behaviour is identical.

Decomposition:
- Shared package alarm_pkg holds:
  - timer state encodings: IDLE 2'b00, COUNTING 2'b01, EXPIRED 2'b10, all other codes decode to IDLE;
  - TIME_W = 4;
  - default CLK_FREQ_HZ.
- One natural sub-module, tick_gen: prescaler, phase bit, and the one_hz/half_hz outputs, plus a sync-clear input driven by start_edge.
- The countdown FSM stays in alarm_timer.

Test Plan (CLK_FREQ_HZ=4):
- Reset, then idle for 20 cycles: expired = 0. one_hz_enable pulses at cycles 4, 8, 12 … after reset release. half_hz_enable pulses at 8, 16.
- value = 3, start_timer pulsed at cycle k: expired rises at k+13 and stays high. start_timer held high for 30 cycles: no restart.
- value = 0, start pulse: expired high at k+1.
- value = 5, start; at k+10 a second start edge with value = 2: expired rises at (k+10)+9, not before.
- value = 2, start; reset asserted at k+5: expired = 0 and IDLE immediately. A later start with value = 1 expires after exactly 5 cycles.
- value = 1, start edge coincident with the final tick of a prior count: the count reloads, and expired stays 0 until 5 cycles later.
